// File: rtl/cgra_pkg.sv
// Shared constants and helpers for CGRA datapath blocks.
// Holds the default word width and a constant-foldable ceil(log2).
package cgra_pkg;

    localparam int DEFAULT_DATA_WIDTH = 512;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Purpose: DEPTH x DATA_WIDTH simple dual-port storage, synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none; the caller gates we. No reset so it maps onto LUTRAM.
module stream_fifo_mem
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Purpose: elastic FWFT FIFO with valid/ready on both sides, occupancy flags and high-water mark.
// Latency: a word pushed into an empty FIFO appears on out_data one cycle later; no bypass.
// Backpressure: in_ready drops when full (no push-through on a pop); out_valid drops when empty.
module stream_fifo
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int CNT_W      = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      max_count
);

    localparam int                PTR_W     = clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

    // Held low during reset so a producer never sees a handshake that the reset discards.
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Explicit wrap keeps non-power-of-two depths legal.
    assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_next;
            // count_next never exceeds DEPTH, so the mark saturates there on its own.
            if (count_next > max_count) begin
                max_count <= count_next;
            end
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: vector table and directed sequences on a DEPTH=16 instance,
// queue-model comparison under wrap and random traffic on a DEPTH=5 instance.
module tb_stream_fifo;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DEPTH=16 instance
    logic          a_rst, a_flush, a_iv, a_irdy, a_ov, a_ordy;
    logic [DW-1:0] a_id, a_od;
    logic          a_full, a_empty, a_af, a_ae;
    logic [4:0]    a_cnt, a_max;

    // DEPTH=5 instance
    logic          b_rst, b_flush, b_iv, b_irdy, b_ov, b_ordy;
    logic [DW-1:0] b_id, b_od;
    logic          b_full, b_empty, b_af, b_ae;
    logic [2:0]    b_cnt, b_max;

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_irdy),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy),
        .full(a_full), .empty(a_empty), .count(a_cnt),
        .almost_full(a_af), .almost_empty(a_ae), .max_count(a_max)
    );

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(5)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_iv), .in_data(b_id), .in_ready(b_irdy),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy),
        .full(b_full), .empty(b_empty), .count(b_cnt),
        .almost_full(b_af), .almost_empty(b_ae), .max_count(b_max)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          rst, flush, iv;
        logic [31:0] id;
        int          ordy;
        int          irdy, ov;
        logic [31:0] od;
        int          cnt, full, empty, af, ae, mx;
    } vec_t;

    vec_t tbl[8];

    // Reference for the DEPTH=5 instance: contents as a queue plus the high-water mark.
    logic [31:0] q5[$];
    int          mx5;

    task automatic cyc5(input logic rst, input logic fl, input logic iv, input logic [31:0] id,
                        input logic ordy, output logic acc, output logic popd, output logic [31:0] pdat);
        int   sz;
        logic eir, eov;
        b_rst = rst; b_flush = fl; b_iv = iv; b_id = id; b_ordy = ordy;
        #1;
        sz  = q5.size();
        eir = !rst && (sz < 5);
        eov = (sz > 0);
        chk("b_in_ready", b_irdy, eir);
        chk("b_out_valid", b_ov, eov);
        if (eov) chk("b_out_data", b_od, q5[0]);
        chk("b_count", b_cnt, sz);
        chk("b_full", b_full, sz == 5);
        chk("b_empty", b_empty, sz == 0);
        chk("b_almost_full", b_af, sz >= 3);
        chk("b_almost_empty", b_ae, sz <= 1);
        chk("b_max_count", b_max, mx5);
        acc  = iv && eir;
        popd = eov && ordy;
        pdat = b_od;
        @(posedge clk); #1;
        if (rst || fl) begin
            q5.delete();
            mx5  = 0;
            acc  = 1'b0;
            popd = 1'b0;
        end else begin
            if (popd) void'(q5.pop_front());
            if (acc) q5.push_back(id);
            if (q5.size() > mx5) mx5 = q5.size();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        acc, popd;
        logic [31:0] pdat;
        logic [31:0] got[$];
        int          idx;

        tbl[0] = '{0, 0, 0, 'h00, 0,  1, 0, 'h00, 0, 0, 1, 0, 1, 0};
        tbl[1] = '{0, 0, 1, 'h11, 0,  1, 0, 'h00, 0, 0, 1, 0, 1, 0};
        tbl[2] = '{0, 0, 1, 'hAA, 1,  1, 1, 'h11, 1, 0, 0, 0, 1, 1};
        tbl[3] = '{0, 0, 0, 'h00, 0,  1, 1, 'hAA, 1, 0, 0, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 'h00, 1,  1, 1, 'hAA, 1, 0, 0, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 'h00, 0,  1, 0, 'h00, 0, 0, 1, 0, 1, 1};
        tbl[6] = '{0, 1, 1, 'h77, 0,  1, 0, 'h00, 0, 0, 1, 0, 1, 1};
        tbl[7] = '{0, 0, 0, 'h00, 0,  1, 0, 'h00, 0, 0, 1, 0, 1, 0};

        a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b1; a_id = 32'h55; a_ordy = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_id = '0;     b_ordy = 1'b0;

        // Reset held two cycles with a word offered.
        #1;
        chk("rst_in_ready_c0", a_irdy, 0);
        @(posedge clk); #1;
        chk("rst_in_ready_c1", a_irdy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            a_rst = tbl[i].rst != 0; a_flush = tbl[i].flush != 0; a_iv = tbl[i].iv != 0;
            a_id = tbl[i].id; a_ordy = tbl[i].ordy != 0;
            #1;
            chk($sformatf("vec%0d in_ready", i), a_irdy, tbl[i].irdy);
            chk($sformatf("vec%0d out_valid", i), a_ov, tbl[i].ov);
            if (tbl[i].ov != 0) chk($sformatf("vec%0d out_data", i), a_od, tbl[i].od);
            chk($sformatf("vec%0d count", i), a_cnt, tbl[i].cnt);
            chk($sformatf("vec%0d full", i), a_full, tbl[i].full);
            chk($sformatf("vec%0d empty", i), a_empty, tbl[i].empty);
            chk($sformatf("vec%0d almost_full", i), a_af, tbl[i].af);
            chk($sformatf("vec%0d almost_empty", i), a_ae, tbl[i].ae);
            chk($sformatf("vec%0d max_count", i), a_max, tbl[i].mx);
            @(posedge clk); #1;
        end

        // Fill 0x1..0x10 with the consumer stalled.
        a_flush = 1'b0; a_ordy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_iv = 1'b1; a_id = 32'(i + 1);
            #1;
            chk($sformatf("fill%0d count", i), a_cnt, i);
            chk($sformatf("fill%0d almost_full", i), a_af, i >= 14);
            chk($sformatf("fill%0d in_ready", i), a_irdy, 1);
            @(posedge clk); #1;
        end
        a_id = 32'h11;
        #1;
        chk("full_flag", a_full, 1);
        chk("full_in_ready", a_irdy, 0);
        chk("full_count", a_cnt, 16);
        chk("full_head", a_od, 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("full_hold%0d count", i), a_cnt, 16);
        end

        // Pop at full with a word still offered: no push-through.
        a_ordy = 1'b1;
        #1;
        chk("fullpop in_ready", a_irdy, 0);
        chk("fullpop out_data", a_od, 32'h1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        #1;
        chk("fullpop count", a_cnt, 15);

        for (int j = 2; j <= 16; j++) begin
            #1;
            chk($sformatf("drain%0d out_data", j), a_od, 32'(j));
            chk($sformatf("drain%0d count", j), a_cnt, 17 - j);
            chk($sformatf("drain%0d almost_empty", j), a_ae, (17 - j) <= 1);
            @(posedge clk); #1;
        end
        a_ordy = 1'b0;
        #1;
        chk("drained empty", a_empty, 1);
        chk("drained out_valid", a_ov, 0);
        chk("drained max_count", a_max, 16);

        // Flush at count=7 with both sides active.
        for (int k = 0; k < 7; k++) begin
            a_iv = 1'b1; a_id = 32'(32'h21 + k);
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        #1;
        chk("preflush count", a_cnt, 7);
        a_flush = 1'b1; a_iv = 1'b1; a_id = 32'hEE; a_ordy = 1'b1;
        #1;
        chk("flush in_ready", a_irdy, 1);
        @(posedge clk); #1;
        a_flush = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;
        #1;
        chk("postflush count", a_cnt, 0);
        chk("postflush empty", a_empty, 1);
        chk("postflush max_count", a_max, 0);
        chk("postflush out_valid", a_ov, 0);
        a_iv = 1'b1; a_id = 32'h30;
        @(posedge clk); #1;
        a_iv = 1'b0;
        #1;
        chk("postflush head", a_od, 32'h30);
        chk("postflush count1", a_cnt, 1);

        // DEPTH=5: wrap with out_ready toggling 1,0,1,0.
        q5.delete();
        mx5 = 0;
        cyc5(1'b1, 1'b0, 1'b0, '0, 1'b0, acc, popd, pdat);
        idx = 0;
        for (int c = 0; c < 80 && (idx < 20 || q5.size() > 0); c++) begin
            cyc5(1'b0, 1'b0, idx < 20, 32'(32'h100 + idx), (c % 2) == 0, acc, popd, pdat);
            if (acc) idx++;
            if (popd) got.push_back(pdat);
        end
        chk("wrap accepted", idx, 20);
        chk("wrap delivered", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            chk($sformatf("wrap order%0d", i), got[i], 32'(32'h100 + i));
        end
        chk("wrap max_count", b_max, 5);

        // DEPTH=5: random traffic with occasional flush and mid-stream reset.
        for (int c = 0; c < 800; c++) begin
            cyc5($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 3) < ((c < 400) ? 1 : 3), acc, popd, pdat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
